hazard_ctrl_unit: RTL and testbench
===================================

# hazard_ctrl_unit

Parametrised pipeline hazard controller for the RV32IM 5-stage core, replacing the purely combinational load-use stall with a registered controller. Detects load-use and (optionally) all RAW hazards, freezes the pipe for multi-cycle divides and data-memory wait states, and squashes wrong-path instructions on taken branches. Drives the per-stage enable/flush inputs of the PC and the IF/ID, ID/EX and EX/MEM registers, plus a saturating stall-cycle counter and a sticky memory-timeout flag.

## Interface
- REG_W, 5, register-address width
- FORWARD_EN, 1, 1 = EX/MEM/WB forwarding present (stall only on load-use); 0 = stall on any RAW against EX or MEM
- DIV_CYCLES, 32, divide freeze length in cycles; 0 disables the divide path
- MEM_TIMEOUT, 255, consecutive dmem wait cycles before mem_timeout sets
- CNT_W, 32, stall counter width
- clk  in  1  core clock
- reset_n  in  1  synchronous, active-low reset
- id_rs1, id_rs2  in  REG_W  ID-stage source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- ex_rd, mem_rd  in  REG_W  destination in EX / MEM
- ex_reg_write, mem_reg_write  in  1  stage writes rd
- ex_mem_read  in  1  EX instruction is a load
- ex_div_start  in  1  EX holds DIV/DIVU/REM/REMU
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- mem_req, dmem_ready  in  1  MEM-stage access pending / memory accepts
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1  stage advance enables
- if_id_flush, id_ex_flush  out  1  load NOP into register
- ex_mem_bubble  out  1  load NOP into EX/MEM
- mem_timeout  out  1  sticky error
- stall_cycles  out  CNT_W  cycles with pc_en=0, saturating

## Operation
- States: RUN, DIV_BUSY, DIV_DONE, MEM_WAIT. Reset: RUN, div counter 0, wait counter 0, mem_timeout 0, stall_cycles 0.
- Outputs combinational from state + inputs. Default: all enables 1, all flushes/bubble 0.
- Register 0 never matches (rd==0 ignored).
- Priority, highest first:
  1. Mem freeze: mem_req && !dmem_ready -> all enables 0, no flushes. State MEM_WAIT while held; back to previous class (RUN or DIV_*) when dmem_ready.
  2. Divide: in RUN, ex_div_start with DIV_CYCLES>0 -> DIV_BUSY, counter=DIV_CYCLES-1. In DIV_BUSY: pc_en=if_id_en=id_ex_en=0, ex_mem_bubble=1; counter decrements each cycle (also during mem freeze); at 0 and not frozen -> DIV_DONE. DIV_DONE: one normal cycle, ex_div_start ignored, -> RUN.
  3. Branch: ex_branch_taken -> if_id_flush=id_ex_flush=1, pc_en=1 (redirect wins over load-use).
  4. Data hazard: src used && rd match && (ex_mem_read, or FORWARD_EN=0 and ex_reg_write/mem_reg_write) -> pc_en=if_id_en=0, id_ex_flush=1.
- Wait counter counts consecutive freeze cycles, clears on dmem_ready; reaching MEM_TIMEOUT sets mem_timeout until reset. Freeze continues regardless.
- stall_cycles increments every cycle pc_en=0, saturates at all-ones.
- reset_n low mid-divide or mid-wait: next edge returns to reset values unconditionally.

## Timing
- Load-use: detected cycle T, bubble enters EX at T+1, dependent instruction in EX at T+2 (exactly 1 stall cycle).
- Divide start at T: freeze cycles T..T+DIV_CYCLES-1, DIV_DONE at T+DIV_CYCLES (EX advances), RUN at T+DIV_CYCLES+1. Each extra mem-freeze cycle after counter expiry delays DIV_DONE by one.
- Mem freeze zero-latency: effective in the same cycle dmem_ready is low.
- Branch flush: single cycle, no state change.

## Structure
- hazard_pkg: state enum (RUN, DIV_BUSY, DIV_DONE, MEM_WAIT), NOP-encoding constant shared with pipeline registers.
- One sub-module: hazard_src_match (rs vs rd compare incl. x0 and used qualifiers), instantiated for EX and MEM.

## Test plan
- FORWARD_EN=1: LW x5 in EX, ID reads x5 via rs2 -> one cycle pc_en=0, id_ex_flush=1; stall_cycles=1. Same with rd=x0 -> no stall.
- FORWARD_EN=0: ADD x3 in MEM, ID reads x3 -> stall; same case with FORWARD_EN=1 -> no stall.
- DIV_CYCLES=4, ex_div_start at T -> pc_en=0 for T..T+3, ex_mem_bubble=1, DIV_DONE at T+4 with start still high not retriggering.
- dmem_ready low 3 cycles during DIV_BUSY with counter expiring -> all enables 0, DIV_DONE delayed to first ready cycle.
- MEM_TIMEOUT=4, dmem_ready low 6 cycles -> mem_timeout=1 after 4th cycle, stays 1 after ready; reset_n low one edge -> 0, state RUN, stall_cycles 0.
- ex_branch_taken with simultaneous load-use match -> flushes both, pc_en=1, no stall.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: controller state and the
// instruction word the pipeline registers load when flushed or bubbled.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2,
    MEM_WAIT = 2'd3
  } hazard_state_e;

  // ADDI x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/hazard_src_match.sv
// Compares the ID-stage source registers against one downstream destination.
// x0 never matches, and a source only counts when the instruction reads it.
module hazard_src_match #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic             rs1_used,
  input  logic             rs2_used,
  input  logic [REG_W-1:0] rd,
  output logic             match
);

  always_comb begin
    match = (rd != '0) && ((rs1_used && (rs1 == rd)) || (rs2_used && (rs2 == rd)));
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Registered hazard controller: load-use / RAW stalls, divide freeze, dmem wait
// freeze and branch squash, with a stall-cycle counter and sticky timeout flag.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_W       = 5,
  parameter int FORWARD_EN  = 1,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             ex_reg_write,
  input  logic             mem_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_div_start,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output hazard_state_e    dbg_state
);

  localparam int DIV_W  = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
  localparam int WAIT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'((DIV_CYCLES > 0) ? DIV_CYCLES - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hazard_state_e     state_q, state_d;
  hazard_state_e     ret_q, ret_d;
  hazard_state_e     cls, cls_nxt;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [WAIT_W-1:0] wait_q, wait_d, wait_inc;
  logic              timeout_q, timeout_d;
  logic [CNT_W-1:0]  stall_q, stall_d;
  logic              freeze, div_go, data_hazard;
  logic              ex_match, mem_match;

  hazard_src_match #(.REG_W(REG_W)) u_ex_match (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd       (ex_rd),
    .match    (ex_match)
  );

  hazard_src_match #(.REG_W(REG_W)) u_mem_match (
    .rs1      (id_rs1),
    .rs2      (id_rs2),
    .rs1_used (id_rs1_used),
    .rs2_used (id_rs2_used),
    .rd       (mem_rd),
    .match    (mem_match)
  );

  always_comb begin
    freeze = mem_req && !dmem_ready;
    // MEM_WAIT only overlays a freeze; ret_q remembers which class is underneath.
    cls    = (state_q == MEM_WAIT) ? ret_q : state_q;
    div_go = (DIV_CYCLES > 0) && (cls == RUN) && ex_div_start && !freeze;
    data_hazard = (ex_match && (ex_mem_read || ((FORWARD_EN == 0) && ex_reg_write))) ||
                  ((FORWARD_EN == 0) && mem_reg_write && mem_match);

    // The divider keeps counting through a freeze; only the DIV_DONE cycle waits.
    cls_nxt   = cls;
    div_cnt_d = div_cnt_q;
    case (cls)
      RUN: begin
        if (div_go) begin
          cls_nxt   = (DIV_CYCLES == 1) ? DIV_DONE : DIV_BUSY;
          div_cnt_d = DIV_LOAD;
        end
      end
      DIV_BUSY: begin
        if (div_cnt_q != '0) div_cnt_d = div_cnt_q - DIV_W'(1);
        if (div_cnt_q <= DIV_W'(1)) cls_nxt = DIV_DONE;
      end
      DIV_DONE: begin
        if (!freeze) cls_nxt = RUN;
      end
      default: cls_nxt = RUN;
    endcase
    state_d = freeze ? MEM_WAIT : cls_nxt;
    ret_d   = cls_nxt;

    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    if (freeze) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
    end else if (div_go || (cls == DIV_BUSY)) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (data_hazard) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end

    wait_inc  = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    wait_d    = freeze ? wait_inc : '0;
    timeout_d = timeout_q || (freeze && (wait_inc == WAIT_MAX));
    stall_d   = (!pc_en && !(&stall_q)) ? stall_q + CNT_W'(1) : stall_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      div_cnt_q <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      div_cnt_q <= div_cnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
    end
  end

  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: a forwarding and a non-forwarding instance share
// stimulus; hand tables, hand sequences and a cycle-level reference model.
module tb_hazard_ctrl_unit;
  import hazard_pkg::*;

  localparam int DIV_C = 4;
  localparam int MT    = 4;
  localparam int CW    = 8;
  localparam int SMAX  = (1 << CW) - 1;

  // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, ex_mem_bubble}
  localparam logic [6:0] V_RUN   = 7'b1111000;
  localparam logic [6:0] V_STALL = 7'b0011010;
  localparam logic [6:0] V_BR    = 7'b1111110;
  localparam logic [6:0] V_DIV   = 7'b0001001;
  localparam logic [6:0] V_FRZ   = 7'b0000000;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic [4:0] ex_rd;
    logic [4:0] mem_rd;
    logic       ex_reg_write;
    logic       mem_reg_write;
    logic       ex_mem_read;
    logic       ex_div_start;
    logic       ex_branch_taken;
    logic       mem_req;
    logic       dmem_ready;
    logic       reset_n;
  } in_t;

  typedef struct {
    in_t        in;
    logic [6:0] exp_f;
    logic [6:0] exp_n;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd, mem_rd;
  logic       id_rs1_used, id_rs2_used, ex_reg_write, mem_reg_write, ex_mem_read;
  logic       ex_div_start, ex_branch_taken, mem_req, dmem_ready;

  logic          pc_en_f, if_id_en_f, id_ex_en_f, ex_mem_en_f, if_id_flush_f, id_ex_flush_f, bubble_f, to_f;
  logic          pc_en_n, if_id_en_n, id_ex_en_n, ex_mem_en_n, if_id_flush_n, id_ex_flush_n, bubble_n, to_n;
  logic [CW-1:0] stall_f, stall_n;
  hazard_state_e st_f, st_n;
  logic [6:0]    ctrl_f, ctrl_n;

  assign ctrl_f = {pc_en_f, if_id_en_f, id_ex_en_f, ex_mem_en_f, if_id_flush_f, id_ex_flush_f, bubble_f};
  assign ctrl_n = {pc_en_n, if_id_en_n, id_ex_en_n, ex_mem_en_n, if_id_flush_n, id_ex_flush_n, bubble_n};

  hazard_ctrl_unit #(.REG_W(5), .FORWARD_EN(1), .DIV_CYCLES(DIV_C), .MEM_TIMEOUT(MT), .CNT_W(CW)) u_dut_f (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .ex_mem_read(ex_mem_read),
    .ex_div_start(ex_div_start), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_en(pc_en_f), .if_id_en(if_id_en_f), .id_ex_en(id_ex_en_f),
    .ex_mem_en(ex_mem_en_f), .if_id_flush(if_id_flush_f), .id_ex_flush(id_ex_flush_f),
    .ex_mem_bubble(bubble_f), .mem_timeout(to_f), .stall_cycles(stall_f), .dbg_state(st_f)
  );

  hazard_ctrl_unit #(.REG_W(5), .FORWARD_EN(0), .DIV_CYCLES(DIV_C), .MEM_TIMEOUT(MT), .CNT_W(CW)) u_dut_n (
    .clk(clk), .reset_n(reset_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .ex_mem_read(ex_mem_read),
    .ex_div_start(ex_div_start), .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
    .dmem_ready(dmem_ready), .pc_en(pc_en_n), .if_id_en(if_id_en_n), .id_ex_en(id_ex_en_n),
    .ex_mem_en(ex_mem_en_n), .if_id_flush(if_id_flush_n), .id_ex_flush(id_ex_flush_n),
    .ex_mem_bubble(bubble_n), .mem_timeout(to_n), .stall_cycles(stall_n), .dbg_state(st_n)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [6:0] exp_q[$];

  // Reference model, index 0 = forwarding, 1 = no forwarding.
  // m_age: cycles since the current divide started, -1 when none in flight.
  int m_age[2];
  int m_wait[2];
  int m_to[2];
  int m_stall[2];

  function automatic in_t idle_in();
    in_t v;
    v = '0;
    v.dmem_ready = 1'b1;
    v.reset_n    = 1'b1;
    return v;
  endfunction

  function automatic bit src_hits(in_t v, logic [4:0] rd);
    return (rd != 5'd0) && ((v.rs1_used && v.rs1 == rd) || (v.rs2_used && v.rs2 == rd));
  endfunction

  function automatic logic [6:0] model_ctrl(int k, in_t v);
    bit frz, busy, hz;
    frz  = v.mem_req && !v.dmem_ready;
    busy = (m_age[k] >= 0 && m_age[k] < DIV_C) || (m_age[k] < 0 && v.ex_div_start && !frz);
    hz   = (src_hits(v, v.ex_rd) && v.ex_mem_read) ||
           (k == 1 && ((src_hits(v, v.ex_rd) && v.ex_reg_write) ||
                       (src_hits(v, v.mem_rd) && v.mem_reg_write)));
    if (frz) return V_FRZ;
    if (busy) return V_DIV;
    if (v.ex_branch_taken) return V_BR;
    if (hz) return V_STALL;
    return V_RUN;
  endfunction

  task automatic model_update(int k, in_t v, logic [6:0] ctrl);
    bit frz;
    frz = v.mem_req && !v.dmem_ready;
    if (!v.reset_n) begin
      m_age[k] = -1; m_wait[k] = 0; m_to[k] = 0; m_stall[k] = 0;
    end else begin
      if (m_age[k] >= 0) begin
        if (m_age[k] >= DIV_C && !frz) m_age[k] = -1;
        else m_age[k] = m_age[k] + 1;
      end else if (v.ex_div_start && !frz) begin
        m_age[k] = 1;
      end
      if (frz) begin
        m_wait[k] = m_wait[k] + 1;
        if (m_wait[k] >= MT) m_to[k] = 1;
      end else begin
        m_wait[k] = 0;
      end
      if (!ctrl[6] && m_stall[k] < SMAX) m_stall[k] = m_stall[k] + 1;
    end
  endtask

  task automatic check_int(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_vec(string name, logic [6:0] got, logic [6:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive(in_t v);
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_used = v.rs1_used; id_rs2_used = v.rs2_used;
    ex_rd = v.ex_rd; mem_rd = v.mem_rd; ex_reg_write = v.ex_reg_write;
    mem_reg_write = v.mem_reg_write; ex_mem_read = v.ex_mem_read;
    ex_div_start = v.ex_div_start; ex_branch_taken = v.ex_branch_taken;
    mem_req = v.mem_req; dmem_ready = v.dmem_ready; reset_n = v.reset_n;
  endtask

  // One cycle: drive after the edge, sample on the falling edge, then advance the model.
  task automatic apply(in_t v, bit has_tab, logic [6:0] tf, logic [6:0] tn);
    logic [6:0] ef, en;
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    exp_q.push_back(model_ctrl(0, v));
    exp_q.push_back(model_ctrl(1, v));
    ef = exp_q.pop_front();
    en = exp_q.pop_front();
    check_vec("model_ctrl_fwd", ctrl_f, ef);
    check_vec("model_ctrl_nofwd", ctrl_n, en);
    check_int("model_timeout_fwd", int'(to_f), m_to[0]);
    check_int("model_timeout_nofwd", int'(to_n), m_to[1]);
    check_int("model_stall_fwd", int'(stall_f), m_stall[0]);
    check_int("model_stall_nofwd", int'(stall_n), m_stall[1]);
    if (has_tab) begin
      check_vec("tab_ctrl_fwd", ctrl_f, tf);
      check_vec("tab_ctrl_nofwd", ctrl_n, tn);
    end
    model_update(0, v, ef);
    model_update(1, v, en);
  endtask

  vec_t tab[8];

  initial begin
    in_t t, d, fz, rs;

    for (int k = 0; k < 2; k++) begin
      m_age[k] = -1; m_wait[k] = 0; m_to[k] = 0; m_stall[k] = 0;
    end
    t = idle_in();
    t.reset_n = 1'b0;
    drive(t);
    repeat (3) @(posedge clk);

    // reset state
    apply(idle_in(), 1'b1, V_RUN, V_RUN);
    check_int("reset_stall", int'(stall_f), 0);
    check_int("reset_timeout", int'(to_f), 0);
    check_int("reset_state", int'(st_f), int'(RUN));

    tab[0] = '{in: idle_in(), exp_f: V_RUN, exp_n: V_RUN};
    t = idle_in(); t.ex_rd = 5; t.ex_reg_write = 1; t.ex_mem_read = 1; t.rs2 = 5; t.rs2_used = 1;
    tab[1] = '{in: t, exp_f: V_STALL, exp_n: V_STALL};
    t.ex_rd = 0; t.rs2 = 0;
    tab[2] = '{in: t, exp_f: V_RUN, exp_n: V_RUN};
    t = idle_in(); t.mem_rd = 3; t.mem_reg_write = 1; t.rs1 = 3; t.rs1_used = 1;
    tab[3] = '{in: t, exp_f: V_RUN, exp_n: V_STALL};
    t = idle_in(); t.ex_rd = 3; t.ex_reg_write = 1; t.rs1 = 3; t.rs1_used = 1;
    tab[4] = '{in: t, exp_f: V_RUN, exp_n: V_STALL};
    t = idle_in(); t.ex_rd = 5; t.ex_mem_read = 1; t.ex_reg_write = 1; t.rs1 = 5; t.rs1_used = 0;
    tab[5] = '{in: t, exp_f: V_RUN, exp_n: V_RUN};
    t = idle_in(); t.ex_rd = 5; t.ex_mem_read = 1; t.ex_reg_write = 1; t.rs2 = 5; t.rs2_used = 1;
    t.ex_branch_taken = 1;
    tab[6] = '{in: t, exp_f: V_BR, exp_n: V_BR};
    t = idle_in(); t.mem_rd = 0; t.mem_reg_write = 1; t.rs1 = 0; t.rs1_used = 1;
    tab[7] = '{in: t, exp_f: V_RUN, exp_n: V_RUN};

    for (int i = 0; i < 8; i++) apply(tab[i].in, 1'b1, tab[i].exp_f, tab[i].exp_n);
    check_int("lu_stall_count_fwd", int'(stall_f), 1);
    check_int("raw_stall_count_nofwd", int'(stall_n), 3);

    // divide: 4 frozen cycles, then DIV_DONE with start still high
    d = idle_in(); d.ex_div_start = 1;
    for (int i = 0; i < DIV_C; i++) apply(d, 1'b1, V_DIV, V_DIV);
    apply(d, 1'b1, V_RUN, V_RUN);
    check_int("div_done_state", int'(st_f), int'(DIV_DONE));
    apply(idle_in(), 1'b1, V_RUN, V_RUN);
    check_int("div_back_to_run", int'(st_f), int'(RUN));

    // divide with dmem wait across counter expiry
    apply(d, 1'b1, V_DIV, V_DIV);
    apply(d, 1'b1, V_DIV, V_DIV);
    fz = d; fz.mem_req = 1; fz.dmem_ready = 0;
    for (int i = 0; i < 3; i++) apply(fz, 1'b1, V_FRZ, V_FRZ);
    check_int("div_frz_state", int'(st_f), int'(MEM_WAIT));
    fz.dmem_ready = 1;
    apply(fz, 1'b1, V_RUN, V_RUN);
    apply(idle_in(), 1'b1, V_RUN, V_RUN);
    check_int("div_frz_run", int'(st_n), int'(RUN));

    // reset mid-divide
    apply(d, 1'b1, V_DIV, V_DIV);
    rs = d; rs.reset_n = 0;
    apply(rs, 1'b1, V_DIV, V_DIV);
    apply(idle_in(), 1'b1, V_RUN, V_RUN);
    check_int("rst_mid_div_state", int'(st_f), int'(RUN));
    check_int("rst_mid_div_stall", int'(stall_f), 0);

    // mem timeout after 4 consecutive wait cycles, sticky until reset
    fz = idle_in(); fz.mem_req = 1; fz.dmem_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      apply(fz, 1'b1, V_FRZ, V_FRZ);
      check_int("timeout_ramp", int'(to_f), (i >= 5) ? 1 : 0);
    end
    check_int("wait_state", int'(st_f), int'(MEM_WAIT));
    t = idle_in(); t.mem_req = 1;
    apply(t, 1'b1, V_RUN, V_RUN);
    check_int("timeout_sticky", int'(to_f), 1);
    check_int("wait_stall_count", int'(stall_f), 6);
    rs = fz; rs.reset_n = 0;
    apply(rs, 1'b1, V_FRZ, V_FRZ);
    apply(idle_in(), 1'b1, V_RUN, V_RUN);
    check_int("timeout_cleared", int'(to_f), 0);
    check_int("rst_state", int'(st_f), int'(RUN));
    check_int("rst_stall", int'(stall_n), 0);

    // stall counter saturation
    for (int i = 0; i < SMAX + 5; i++) apply(fz, 1'b0, V_FRZ, V_FRZ);
    check_int("stall_saturate", int'(stall_f), SMAX);
    rs = idle_in(); rs.reset_n = 0;
    apply(rs, 1'b0, V_FRZ, V_FRZ);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      t = idle_in();
      t.rs1 = 5'($urandom_range(0, 3));
      t.rs2 = 5'($urandom_range(0, 3));
      t.rs1_used = 1'($urandom_range(0, 1));
      t.rs2_used = 1'($urandom_range(0, 1));
      t.ex_rd = 5'($urandom_range(0, 3));
      t.mem_rd = 5'($urandom_range(0, 3));
      t.ex_reg_write = 1'($urandom_range(0, 1));
      t.mem_reg_write = 1'($urandom_range(0, 1));
      t.ex_mem_read = ($urandom_range(0, 3) == 0);
      t.ex_div_start = ($urandom_range(0, 7) == 0);
      t.ex_branch_taken = ($urandom_range(0, 7) == 0);
      t.mem_req = 1'($urandom_range(0, 1));
      t.dmem_ready = ((i % 200) < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
      t.reset_n = ($urandom_range(0, 249) != 0);
      if ((i % 200) < 12) t.mem_req = 1'b1;
      apply(t, 1'b0, V_RUN, V_RUN);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
